// File: rtl/multicycle_controller_if.sv
// -----------------------------------------------------------------------------
// multicycle_controller_if
// Purpose : Control/status bundle between the CA-3 multi-cycle controller and
//           its datapath and memory.
// Signals : instruction, zero_flag, carry_flag, mem_ready      datapath -> ctrl
//           ld_pc, pc_src, ld_ir, ld_di, ld_alu, alu_op, ld_czn, czn_src,
//           rf_we, rf_wsrc, mem_addr_src, mem_read, mem_write,
//           halted, err                                       ctrl -> datapath
// Modports: master = controller side, slave = datapath/memory side.
// -----------------------------------------------------------------------------
interface multicycle_controller_if;
   logic [3:0] instruction;
   logic       zero_flag;
   logic       carry_flag;
   logic       mem_ready;
   logic       ld_pc;
   logic [1:0] pc_src;
   logic       ld_ir;
   logic       ld_di;
   logic       ld_alu;
   logic [1:0] alu_op;
   logic       ld_czn;
   logic       czn_src;
   logic       rf_we;
   logic [1:0] rf_wsrc;
   logic       mem_addr_src;
   logic       mem_read;
   logic       mem_write;
   logic       halted;
   logic       err;

   modport master (
      input  instruction, zero_flag, carry_flag, mem_ready,
      output ld_pc, pc_src, ld_ir, ld_di, ld_alu, alu_op, ld_czn, czn_src,
             rf_we, rf_wsrc, mem_addr_src, mem_read, mem_write, halted, err
   );

   modport slave (
      output instruction, zero_flag, carry_flag, mem_ready,
      input  ld_pc, pc_src, ld_ir, ld_di, ld_alu, alu_op, ld_czn, czn_src,
             rf_we, rf_wsrc, mem_addr_src, mem_read, mem_write, halted, err
   );
endinterface

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Purpose : Multi-cycle control FSM for the CA-3 datapath. Fetches an opcode
//           word, optionally an operand word, and sequences execution of
//           NOP/HALT/MVR/ALU/LDI/LDR/STR/JMP/BRZ/BRC. Every memory access waits
//           on mem_ready under a watchdog; HALTED and ERROR are sticky.
// Ports   : clk  - system clock, rising edge
//           rst  - asynchronous active-high reset
//           bus  - multicycle_controller_if.master (opcode/flags/mem_ready in,
//                  all datapath loads, selects and memory strobes out)
// Params  : TIMEOUT    - max cycles a memory access waits for mem_ready (1..255)
//           HAS_BRANCH - 1: BRZ/BRC legal, 0: they decode as illegal
// -----------------------------------------------------------------------------
module multicycle_controller #(
   parameter int TIMEOUT    = 16,
   parameter int HAS_BRANCH = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   multicycle_controller_if.master        bus
);

   typedef enum logic [3:0] {
      S_RESET, S_FETCH, S_DECODE, S_MVR_WB, S_ALU_EX, S_ALU_WB, S_OPND,
      S_LDI_WB, S_MEM_RD, S_LDR_WB, S_MEM_WR, S_JMP_EX, S_BR_EX,
      S_HALTED, S_ERROR
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     r_state;
   state_t     w_state_next;
   logic [7:0] r_cnt;
   logic       w_is_wait;
   logic       w_timeout;
   logic       w_branch_ok;
   logic       w_taken;

   assign w_is_wait   = (r_state == S_FETCH) || (r_state == S_OPND) ||
                        (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
   // mem_ready in the last allowed cycle still wins over the watchdog
   assign w_timeout   = !bus.mem_ready && (r_cnt == CNT_LAST);
   assign w_branch_ok = (HAS_BRANCH != 0);
   assign w_taken     = ((bus.instruction == 4'b1100) && bus.zero_flag) ||
                        ((bus.instruction == 4'b1101) && bus.carry_flag);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_RESET;
      else     r_state <= w_state_next;
   end

   // Wait counter: cleared whenever the state changes, so every entry into a
   // wait state (even straight from another wait state) starts at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                         r_cnt <= '0;
      else if (w_state_next != r_state) r_cnt <= '0;
      else if (w_is_wait && !bus.mem_ready) r_cnt <= r_cnt + 8'd1;
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_RESET:  w_state_next = S_FETCH;
         S_FETCH: begin
            if (bus.mem_ready)  w_state_next = S_DECODE;
            else if (w_timeout) w_state_next = S_ERROR;
         end
         S_DECODE: begin
            casez (bus.instruction)
               4'b0000: w_state_next = S_FETCH;
               4'b0001: w_state_next = S_HALTED;
               4'b0010: w_state_next = S_MVR_WB;
               4'b0011: w_state_next = S_OPND;
               4'b01??: w_state_next = S_ALU_EX;
               4'b100?,
               4'b1010,
               4'b1011: w_state_next = S_OPND;
               4'b110?: w_state_next = w_branch_ok ? S_OPND : S_ERROR;
               default: w_state_next = S_ERROR;
            endcase
         end
         S_MVR_WB: w_state_next = S_FETCH;
         S_ALU_EX: w_state_next = S_ALU_WB;
         S_ALU_WB: w_state_next = S_FETCH;
         S_OPND: begin
            if (bus.mem_ready) begin
               casez (bus.instruction)
                  4'b100?: w_state_next = S_LDI_WB;
                  4'b1010: w_state_next = S_MEM_RD;
                  4'b1011: w_state_next = S_MEM_WR;
                  4'b0011: w_state_next = S_JMP_EX;
                  4'b110?: w_state_next = S_BR_EX;
                  default: w_state_next = S_ERROR;
               endcase
            end else if (w_timeout) begin
               w_state_next = S_ERROR;
            end
         end
         S_LDI_WB: w_state_next = S_FETCH;
         S_MEM_RD: begin
            if (bus.mem_ready)  w_state_next = S_LDR_WB;
            else if (w_timeout) w_state_next = S_ERROR;
         end
         S_LDR_WB: w_state_next = S_FETCH;
         S_MEM_WR: begin
            if (bus.mem_ready)  w_state_next = S_FETCH;
            else if (w_timeout) w_state_next = S_ERROR;
         end
         S_JMP_EX: w_state_next = S_FETCH;
         S_BR_EX:  w_state_next = S_FETCH;
         S_HALTED: w_state_next = S_HALTED;
         S_ERROR:  w_state_next = S_ERROR;
         default:  w_state_next = S_ERROR;
      endcase
   end

   // Output logic
   always_comb begin
      bus.ld_pc        = 1'b0;
      bus.pc_src       = 2'd0;
      bus.ld_ir        = 1'b0;
      bus.ld_di        = 1'b0;
      bus.ld_alu       = 1'b0;
      bus.alu_op       = 2'd0;
      bus.ld_czn       = 1'b0;
      bus.czn_src      = 1'b0;
      bus.rf_we        = 1'b0;
      bus.rf_wsrc      = 2'd0;
      bus.mem_addr_src = 1'b0;
      bus.mem_read     = 1'b0;
      bus.mem_write    = 1'b0;
      bus.halted       = 1'b0;
      bus.err          = 1'b0;
      case (r_state)
         S_FETCH: begin
            bus.mem_read = 1'b1;
            bus.ld_ir    = bus.mem_ready;
            bus.ld_pc    = bus.mem_ready;
         end
         S_OPND: begin
            bus.mem_read = 1'b1;
            bus.ld_di    = bus.mem_ready;
            bus.ld_pc    = bus.mem_ready;
         end
         S_MVR_WB: begin
            bus.rf_we   = 1'b1;
            bus.rf_wsrc = 2'd2;
            bus.ld_czn  = 1'b1;
            bus.czn_src = 1'b1;
         end
         S_ALU_EX: begin
            bus.ld_alu = 1'b1;
            bus.alu_op = bus.instruction[1:0];
         end
         S_ALU_WB: begin
            bus.rf_we  = 1'b1;
            bus.ld_czn = 1'b1;
            bus.alu_op = bus.instruction[1:0];
         end
         S_LDI_WB, S_LDR_WB: begin
            bus.rf_we   = 1'b1;
            bus.rf_wsrc = 2'd1;
         end
         S_MEM_RD: begin
            bus.mem_read     = 1'b1;
            bus.mem_addr_src = 1'b1;
            bus.ld_di        = bus.mem_ready;
         end
         S_MEM_WR: begin
            bus.mem_write    = 1'b1;
            bus.mem_addr_src = 1'b1;
         end
         S_JMP_EX: begin
            bus.ld_pc  = 1'b1;
            bus.pc_src = 2'd1;
         end
         S_BR_EX: begin
            bus.ld_pc  = w_taken;
            bus.pc_src = w_taken ? 2'd2 : 2'd0;
         end
         S_HALTED: bus.halted = 1'b1;
         S_ERROR:  bus.err    = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Two controllers share one stimulus: the default build (TIMEOUT=16,
// HAS_BRANCH=1) and a reduced build (TIMEOUT=4, HAS_BRANCH=0). Each test
// queues per-cycle stimulus plus the expected control word, then drains the
// queue one clock at a time, comparing the selected DUT's outputs.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

   typedef struct packed {
      logic       ld_pc;
      logic [1:0] pc_src;
      logic       ld_ir;
      logic       ld_di;
      logic       ld_alu;
      logic [1:0] alu_op;
      logic       ld_czn;
      logic       czn_src;
      logic       rf_we;
      logic [1:0] rf_wsrc;
      logic       mem_addr_src;
      logic       mem_read;
      logic       mem_write;
      logic       halted;
      logic       err;
   } ctl_t;

   typedef struct {
      logic       rst;
      logic       rdy;
      logic       zf;
      logic       cf;
      logic [3:0] ins;
      bit         alt;
      ctl_t       exp;
   } item_t;

   logic  clk = 1'b0;
   logic  rst = 1'b1;
   item_t sb[$];
   int    n_cmp = 0;
   int    n_err = 0;

   multicycle_controller_if mif ();
   multicycle_controller_if aif ();

   multicycle_controller #(.TIMEOUT(16), .HAS_BRANCH(1)) dut (
      .clk(clk), .rst(rst), .bus(mif.master)
   );
   multicycle_controller #(.TIMEOUT(4), .HAS_BRANCH(0)) dut_alt (
      .clk(clk), .rst(rst), .bus(aif.master)
   );

   always #5 clk = ~clk;

   // ---------------- expected control words ----------------
   function automatic ctl_t e_fetch(input logic r);
      ctl_t c = '0;
      c.mem_read = 1'b1;
      c.ld_ir    = r;
      c.ld_pc    = r;
      return c;
   endfunction
   function automatic ctl_t e_opnd(input logic r);
      ctl_t c = '0;
      c.mem_read = 1'b1;
      c.ld_di    = r;
      c.ld_pc    = r;
      return c;
   endfunction
   function automatic ctl_t e_memrd(input logic r);
      ctl_t c = '0;
      c.mem_read     = 1'b1;
      c.mem_addr_src = 1'b1;
      c.ld_di        = r;
      return c;
   endfunction
   function automatic ctl_t e_memwr();
      ctl_t c = '0;
      c.mem_write    = 1'b1;
      c.mem_addr_src = 1'b1;
      return c;
   endfunction
   function automatic ctl_t e_wb(input logic [1:0] src);
      ctl_t c = '0;
      c.rf_we   = 1'b1;
      c.rf_wsrc = src;
      return c;
   endfunction
   function automatic ctl_t e_mvr();
      ctl_t c = e_wb(2'd2);
      c.ld_czn  = 1'b1;
      c.czn_src = 1'b1;
      return c;
   endfunction
   function automatic ctl_t e_aluex(input logic [1:0] op);
      ctl_t c = '0;
      c.ld_alu = 1'b1;
      c.alu_op = op;
      return c;
   endfunction
   function automatic ctl_t e_aluwb(input logic [1:0] op);
      ctl_t c = e_wb(2'd0);
      c.ld_czn = 1'b1;
      c.alu_op = op;
      return c;
   endfunction
   function automatic ctl_t e_pc(input logic [1:0] src);
      ctl_t c = '0;
      c.ld_pc  = 1'b1;
      c.pc_src = src;
      return c;
   endfunction
   function automatic ctl_t e_halt();
      ctl_t c = '0;
      c.halted = 1'b1;
      return c;
   endfunction
   function automatic ctl_t e_err();
      ctl_t c = '0;
      c.err = 1'b1;
      return c;
   endfunction

   function automatic ctl_t obs_of(input bit alt);
      ctl_t c;
      if (alt)
         c = '{aif.ld_pc, aif.pc_src, aif.ld_ir, aif.ld_di, aif.ld_alu, aif.alu_op,
               aif.ld_czn, aif.czn_src, aif.rf_we, aif.rf_wsrc, aif.mem_addr_src,
               aif.mem_read, aif.mem_write, aif.halted, aif.err};
      else
         c = '{mif.ld_pc, mif.pc_src, mif.ld_ir, mif.ld_di, mif.ld_alu, mif.alu_op,
               mif.ld_czn, mif.czn_src, mif.rf_we, mif.rf_wsrc, mif.mem_addr_src,
               mif.mem_read, mif.mem_write, mif.halted, mif.err};
      return c;
   endfunction

   // ---------------- stimulus plumbing ----------------
   task automatic push(input logic r, input logic rdy, input logic zf, input logic cf,
                       input logic [3:0] ins, input bit alt, input ctl_t e);
      item_t it;
      it.rst = r; it.rdy = rdy; it.zf = zf; it.cf = cf;
      it.ins = ins; it.alt = alt; it.exp = e;
      sb.push_back(it);
   endtask

   // Reset pulse followed by the one RESET cycle seen after release.
   task automatic push_rst(input bit alt);
      push(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, alt, '0);
      push(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, alt, '0);
   endtask

   task automatic apply(input item_t it);
      rst             = it.rst;
      mif.mem_ready   = it.rdy;  aif.mem_ready   = it.rdy;
      mif.zero_flag   = it.zf;   aif.zero_flag   = it.zf;
      mif.carry_flag  = it.cf;   aif.carry_flag  = it.cf;
      mif.instruction = it.ins;  aif.instruction = it.ins;
   endtask

   // Fetch + decode with mem_ready high for a given opcode
   task automatic push_fd(input logic [3:0] op, input bit alt);
      push(1'b0, 1'b1, 1'b0, 1'b0, op, alt, e_fetch(1'b1));
      push(1'b0, 1'b1, 1'b0, 1'b0, op, alt, '0);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      item_t it; ctl_t obs; int k = 0;
      push_rst(1'b0);
      push(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, e_fetch(1'b0));
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, e_fetch(1'b1));
      while (sb.size() > 0) begin
         it = sb.pop_front();
         @(posedge clk); #1 apply(it);
         @(negedge clk); obs = obs_of(it.alt);
         n_cmp++;
         if (obs !== it.exp) begin
            n_err++;
            $display("FAIL reset step %0d: got %h required %h", k, obs, it.exp);
         end
         k++;
      end
   endtask

   task automatic test_nop_mvr();
      item_t it; ctl_t obs; int k = 0;
      push_rst(1'b0);
      push_fd(4'b0000, 1'b0);
      push_fd(4'b0010, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 1'b0, e_mvr());
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, e_fetch(1'b1));
      while (sb.size() > 0) begin
         it = sb.pop_front();
         @(posedge clk); #1 apply(it);
         @(negedge clk); obs = obs_of(it.alt);
         n_cmp++;
         if (obs !== it.exp) begin
            n_err++;
            $display("FAIL nop_mvr step %0d: got %h required %h", k, obs, it.exp);
         end
         k++;
      end
   endtask

   task automatic test_alu();
      item_t it; ctl_t obs; int k = 0;
      push_rst(1'b0);
      push_fd(4'b0110, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b0, e_aluex(2'b10));
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b0110, 1'b0, e_aluwb(2'b10));
      push_fd(4'b0101, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 1'b0, e_aluex(2'b01));
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 1'b0, e_aluwb(2'b01));
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, e_fetch(1'b1));
      while (sb.size() > 0) begin
         it = sb.pop_front();
         @(posedge clk); #1 apply(it);
         @(negedge clk); obs = obs_of(it.alt);
         n_cmp++;
         if (obs !== it.exp) begin
            n_err++;
            $display("FAIL alu step %0d: got %h required %h", k, obs, it.exp);
         end
         k++;
      end
   endtask

   task automatic test_load_jump();
      item_t it; ctl_t obs; int k = 0;
      push_rst(1'b0);
      // LDR with three wait cycles in MEM_RD
      push_fd(4'b1010, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b0, e_opnd(1'b1));
      for (int i = 0; i < 3; i++)
         push(1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b0, e_memrd(1'b0));
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b0, e_memrd(1'b1));
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b1010, 1'b0, e_wb(2'd1));
      // LDI with one wait cycle on the operand fetch
      push_fd(4'b1001, 1'b0);
      push(1'b0, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0, e_opnd(1'b0));
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b1001, 1'b0, e_opnd(1'b1));
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b1001, 1'b0, e_wb(2'd1));
      // JMP
      push_fd(4'b0011, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 1'b0, e_opnd(1'b1));
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b0011, 1'b0, e_pc(2'd1));
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, e_fetch(1'b1));
      while (sb.size() > 0) begin
         it = sb.pop_front();
         @(posedge clk); #1 apply(it);
         @(negedge clk); obs = obs_of(it.alt);
         n_cmp++;
         if (obs !== it.exp) begin
            n_err++;
            $display("FAIL load_jump step %0d: got %h required %h", k, obs, it.exp);
         end
         k++;
      end
   endtask

   task automatic test_branch();
      item_t it; ctl_t obs; int k = 0;
      logic [3:0] ops[4] = '{4'b1100, 4'b1100, 4'b1101, 4'b1101};
      logic       zfs[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic       cfs[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic       tkn[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      push_rst(1'b0);
      for (int i = 0; i < 4; i++) begin
         push_fd(ops[i], 1'b0);
         push(1'b0, 1'b1, 1'b0, 1'b0, ops[i], 1'b0, e_opnd(1'b1));
         push(1'b0, 1'b1, zfs[i], cfs[i], ops[i], 1'b0, tkn[i] ? e_pc(2'd2) : ctl_t'('0));
      end
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, e_fetch(1'b1));
      // reduced build: 1100 is illegal and lands in ERROR right after DECODE
      push_rst(1'b1);
      push_fd(4'b1100, 1'b1);
      push(1'b0, 1'b1, 1'b1, 1'b0, 4'b1100, 1'b1, e_err());
      while (sb.size() > 0) begin
         it = sb.pop_front();
         @(posedge clk); #1 apply(it);
         @(negedge clk); obs = obs_of(it.alt);
         n_cmp++;
         if (obs !== it.exp) begin
            n_err++;
            $display("FAIL branch step %0d: got %h required %h", k, obs, it.exp);
         end
         k++;
      end
   endtask

   task automatic test_halt_illegal();
      item_t it; ctl_t obs; int k = 0;
      push_rst(1'b0);
      push_fd(4'b0001, 1'b0);
      for (int i = 0; i < 3; i++)
         push(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, e_halt());
      push_rst(1'b0);
      push_fd(4'b1110, 1'b0);
      for (int i = 0; i < 2; i++)
         push(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, e_err());
      while (sb.size() > 0) begin
         it = sb.pop_front();
         @(posedge clk); #1 apply(it);
         @(negedge clk); obs = obs_of(it.alt);
         n_cmp++;
         if (obs !== it.exp) begin
            n_err++;
            $display("FAIL halt_illegal step %0d: got %h required %h", k, obs, it.exp);
         end
         k++;
      end
   endtask

   task automatic test_timeout();
      item_t it; ctl_t obs; int k = 0;
      push_rst(1'b1);
      for (int i = 0; i < 4; i++)
         push(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, e_fetch(1'b0));
      for (int i = 0; i < 3; i++)
         push(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, e_err());
      push_rst(1'b1);
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, e_fetch(1'b1));
      // ready in the last allowed cycle completes normally (reduced build)
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, '0);
      for (int i = 0; i < 3; i++)
         push(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, e_fetch(1'b0));
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, e_fetch(1'b1));
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, '0);
      while (sb.size() > 0) begin
         it = sb.pop_front();
         @(posedge clk); #1 apply(it);
         @(negedge clk); obs = obs_of(it.alt);
         n_cmp++;
         if (obs !== it.exp) begin
            n_err++;
            $display("FAIL timeout step %0d: got %h required %h", k, obs, it.exp);
         end
         k++;
      end
   endtask

   task automatic test_back_to_back();
      item_t it; ctl_t obs; int k = 0;
      push_rst(1'b0);
      // STR completing after two wait cycles, then another STR cut by rst
      push_fd(4'b1011, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b1011, 1'b0, e_opnd(1'b1));
      push(1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, e_memwr());
      push(1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, e_memwr());
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b1011, 1'b0, e_memwr());
      push_fd(4'b1011, 1'b0);
      push(1'b0, 1'b1, 1'b0, 1'b0, 4'b1011, 1'b0, e_opnd(1'b1));
      push(1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, e_memwr());
      push(1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, '0);
      push(1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, '0);
      push(1'b0, 1'b0, 1'b0, 1'b0, 4'b1011, 1'b0, e_fetch(1'b0));
      while (sb.size() > 0) begin
         it = sb.pop_front();
         @(posedge clk); #1 apply(it);
         @(negedge clk); obs = obs_of(it.alt);
         n_cmp++;
         if (obs !== it.exp) begin
            n_err++;
            $display("FAIL back_to_back step %0d: got %h required %h", k, obs, it.exp);
         end
         k++;
      end
   endtask

   initial begin
      mif.instruction = 4'd0; mif.zero_flag = 1'b0; mif.carry_flag = 1'b0; mif.mem_ready = 1'b0;
      aif.instruction = 4'd0; aif.zero_flag = 1'b0; aif.carry_flag = 1'b0; aif.mem_ready = 1'b0;
      test_reset();
      test_nop_mvr();
      test_alu();
      test_load_jump();
      test_branch();
      test_halt_illegal();
      test_timeout();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Parametrised next-generation multi-cycle control FSM for the CA-3 datapath.
- Extends LDI/MVR-only control to a full instruction set: NOP, HALT, MVR, ALU ops, LDI, LDR, STR, JMP, BRZ, BRC.
- Adds a mem_ready handshake with a timeout watchdog, plus sticky halt and error states.
- Sits beside the datapath: it takes the IR opcode and the flags, and drives every load, select and memory strobe.

Parameters:
- TIMEOUT, 16: maximum cycles a memory access may wait for mem_ready; range 1..255.
- HAS_BRANCH, 1: 1 means BRZ and BRC are legal; 0 means their opcodes decode as illegal.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- instruction  input  4  opcode from IR; stable outside FETCH.
- zero_flag  input  1  Z from CZN register.
- carry_flag  input  1  C from CZN register.
- mem_ready  input  1  memory completes the current read/write this cycle.
- ld_pc  output  1  PC load enable.
- pc_src  output  2  PC source: 0 PC+1, 1 DI (absolute), 2 PC+DI (relative).
- ld_ir  output  1  IR load enable.
- ld_di  output  1  DI load enable.
- ld_alu  output  1  ALU result register load.
- alu_op  output  2  ALU function.
- ld_czn  output  1  CZN load enable.
- czn_src  output  1  CZN source: 0 ALU, 1 RF.
- rf_we  output  1  register-file write enable.
- rf_wsrc  output  2  RF write data: 0 ALU, 1 DI, 2 reg1.
- mem_addr_src  output  1  memory address: 0 PC, 1 DI.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- halted  output  1  HALT executed.
- err  output  1  illegal opcode or memory timeout.

Behaviour:
- State register and wait counter are reset asynchronously on rst. Reset enters RESET, where all outputs are 0.
- Outputs not listed for a state are 0. Outputs are combinational from state, plus mem_ready, flags and instruction where stated.
- Opcodes:
  - 0000 NOP; 0001 HALT; 0010 MVR; 0011 JMP.
  - 01xx ALU, with alu_op = instruction[1:0].
  - 100x LDI; 1010 LDR; 1011 STR; 1100 BRZ; 1101 BRC.
  - 1110 and 1111 are illegal.
- RESET -> FETCH, unconditionally on the next edge.
- FETCH:
  - mem_read=1, mem_addr_src=0.
  - When mem_ready=1: ld_ir=1, ld_pc=1, pc_src=0, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE (1 cycle, no outputs) dispatches on the opcode:
  - NOP -> FETCH.
  - HALT -> HALTED.
  - MVR -> MVR_WB.
  - ALU -> ALU_EX.
  - LDI, LDR, STR, JMP, BRZ, BRC -> OPND.
  - Illegal -> ERROR.
- MVR_WB: rf_we=1, rf_wsrc=2, ld_czn=1, czn_src=1; then FETCH.
- ALU_EX: ld_alu=1, alu_op=instr[1:0]; then ALU_WB.
- ALU_WB: rf_we=1, rf_wsrc=0, ld_czn=1, czn_src=0, alu_op held; then FETCH.
- OPND (operand-word fetch):
  - Outputs same as FETCH, except on mem_ready: ld_di=1, ld_pc=1, pc_src=0.
  - Next state by opcode: LDI -> LDI_WB, LDR -> MEM_RD, STR -> MEM_WR, JMP -> JMP_EX, BRZ/BRC -> BR_EX.
- LDI_WB: rf_we=1, rf_wsrc=1; then FETCH.
- MEM_RD:
  - mem_read=1, mem_addr_src=1.
  - On mem_ready: ld_di=1, next state LDR_WB.
- LDR_WB: rf_we=1, rf_wsrc=1; then FETCH.
- MEM_WR: mem_write=1, mem_addr_src=1; on mem_ready -> FETCH.
- JMP_EX: ld_pc=1, pc_src=1; then FETCH.
- BR_EX:
  - When taken (BRZ with zero_flag=1, or BRC with carry_flag=1): ld_pc=1, pc_src=2.
  - Not taken: no outputs.
  - Either way, then FETCH.
- Wait states are FETCH, OPND, MEM_RD and MEM_WR.
  - The wait counter clears on entry to each wait state.
  - It increments each cycle mem_ready=0.
  - If mem_ready=0 while the counter == TIMEOUT-1, the next state is ERROR.
  - mem_ready=1 in that same cycle completes the access normally.
- HALTED: halted=1, absorbing; only rst exits.
- ERROR: err=1, absorbing; only rst exits.
- mem_read and mem_write are never 1 in the same cycle. Every access takes at least 1 cycle; with mem_ready tied high, each wait state lasts exactly 1 cycle.
- rst asserted mid-instruction: outputs drop to 0 in the same cycle, with no partial writeback.

Test Plan:
- mem_ready tied 1, NOP then MVR -> FETCH, DECODE, FETCH, DECODE, MVR_WB. rf_we=1 with rf_wsrc=2 exactly in cycle 5; 2-cycle NOP, 3-cycle MVR.
- ALU opcode 0110, mem_ready=1 -> ld_alu=1 with alu_op=2'b10 in cycle 3; rf_we=1, ld_czn=1, czn_src=0 in cycle 4; then FETCH.
- LDR, mem_ready low 3 cycles in MEM_RD -> mem_read=1 and mem_addr_src=1 held 4 cycles; ld_di=1 only in the ready cycle; rf_we=1, rf_wsrc=1 the next cycle.
- BRZ with zero_flag=1 -> BR_EX has ld_pc=1, pc_src=2. Repeat with zero_flag=0 -> ld_pc=0. With HAS_BRANCH=0, opcode 1100 -> err=1 after DECODE.
- TIMEOUT=4, mem_ready held 0 in FETCH -> mem_read high 4 cycles, then err=1 with mem_read=0. err stays set with mem_ready=1, until rst clears it.
- rst pulsed during MEM_WR -> mem_write falls in the same cycle; after release, RESET for 1 cycle, then FETCH with mem_read=1.
